mem_arbiter: RTL and testbench

- Two-master to one-slave arbiter on the picorv32-style native memory interface.
- Sits between the core and memory. The instruction master is the fetcher; the data master is the load/store stage.
- One outstanding transaction at a time.
- Registered request outputs, one-cycle response pulse back to the granted master.
- Round-robin when both masters request in the same cycle.

---
 rtl/mem_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master round-robin arbiter onto a picorv32-style native memory port.
// Define MEM_ARBITER_TIMEOUT_EN to abort stalled requests after TIMEOUT_CYCLES and raise bus_error.
module mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_valid,
    input  logic [31:0] i_addr,
    output logic        i_ready,
    output logic [31:0] i_rdata,
    input  logic        d_valid,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic        mem_valid,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        bus_error
);
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t      state_q, state_d;
    logic        last_data_q, last_data_d;
    logic        mem_valid_q, mem_valid_d;
    logic        mem_instr_q, mem_instr_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic        i_ready_q, i_ready_d;
    logic        d_ready_q, d_ready_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        pick_data, expire, done;
    logic [31:0] resp_data;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535 || TIMEOUT_CYCLES > (1 << CNT_W)) begin : g_bad_cfg
        $error("mem_arbiter: TIMEOUT_CYCLES does not fit the 1..65535 range or CNT_W");
    end

`ifdef MEM_ARBITER_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bus_error_q, bus_error_d;

    // Counter sits at zero outside REQ, so it is already clear on REQ entry.
    assign cnt_d       = (state_q == REQ) ? cnt_q + 1'b1 : '0;
    assign expire      = (state_q == REQ) && !mem_ready && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign bus_error_d = bus_error_q | expire;
    assign bus_error   = bus_error_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q       <= '0;
            bus_error_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            bus_error_q <= bus_error_d;
        end
    end
`else
    assign expire    = 1'b0;
    assign bus_error = 1'b0;
`endif

    // last_data_q doubles as the current owner while a transaction is in flight.
    assign pick_data = d_valid && (!i_valid || !last_data_q);
    assign done      = mem_ready || expire;
    assign resp_data = mem_ready ? mem_rdata : 32'h0;

    always_comb begin
        state_d     = state_q;
        last_data_d = last_data_q;
        mem_valid_d = mem_valid_q;
        mem_instr_d = mem_instr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_ready_d   = 1'b0;
        d_ready_d   = 1'b0;
        case (state_q)
            IDLE: if (i_valid || d_valid) begin
                state_d     = REQ;
                last_data_d = pick_data;
                mem_valid_d = 1'b1;
                mem_instr_d = !pick_data;
                mem_addr_d  = pick_data ? d_addr : i_addr;
                mem_wdata_d = pick_data ? d_wdata : 32'h0;
                mem_wstrb_d = pick_data ? d_wstrb : 4'h0;
            end
            REQ: if (done) begin
                state_d     = RESP;
                mem_valid_d = 1'b0;
                mem_instr_d = 1'b0;
                i_ready_d   = !last_data_q;
                d_ready_d   = last_data_q;
                i_rdata_d   = last_data_q ? i_rdata_q : resp_data;
                d_rdata_d   = last_data_q ? resp_data : d_rdata_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            last_data_q <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_instr_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            i_ready_q   <= 1'b0;
            d_ready_q   <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            last_data_q <= last_data_d;
            mem_valid_q <= mem_valid_d;
            mem_instr_q <= mem_instr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            i_ready_q   <= i_ready_d;
            d_ready_q   <= d_ready_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign mem_valid = mem_valid_q;
    assign mem_instr = mem_instr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign i_ready   = i_ready_q;
    assign d_ready   = d_ready_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random checks of mem_arbiter against a transaction-level model.
// Build with MEM_ARBITER_TIMEOUT_EN to exercise the timeout path (TIMEOUT_CYCLES=4).
module tb_mem_arbiter;
`ifdef MEM_ARBITER_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 255;
`endif

    logic        clk = 1'b0, reset = 1'b0;
    logic        i_valid = 1'b0, d_valid = 1'b0, mem_ready = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
    logic [3:0]  d_wstrb = '0;
    logic        i_ready, d_ready, mem_valid, mem_instr, bus_error;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;

    int checks = 0, failures = 0;

    // Model: e = index of the next clock edge; a grant may happen at edge >= nfree.
    int          e = 0, g = 0, nfree = 0;
    bit          act = 0, own_d = 0, last_d = 0, berr = 0;
    logic        e_mv, e_mi, e_ir, e_dr;
    logic [31:0] e_ma, e_mw, e_id, e_dd;
    logic [3:0]  e_ms;

    bit          i_pend = 0, d_pend = 0, i_cool = 0, d_cool = 0, prev_mv = 0;
    logic [31:0] ia = '0, da = '0, dw = '0;
    logic [3:0]  ds = '0;
    bit          order[$];

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .i_valid(i_valid), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
        .d_valid(d_valid), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .bus_error(bus_error)
    );

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        act = 0; last_d = 0; berr = 0; nfree = e;
        e_mv = 0; e_mi = 0; e_ir = 0; e_dr = 0;
        e_ma = '0; e_mw = '0; e_ms = '0; e_id = '0; e_dd = '0;
    endtask

    // Drive inputs for one edge, predict its outcome, clock, then compare.
    task automatic step(input logic iv, input logic [31:0] a_i, input logic dv,
                        input logic [31:0] a_d, input logic [31:0] w_d, input logic [3:0] s_d,
                        input logic mr, input logic [31:0] md);
        bit tmo;
        i_valid = iv; i_addr = a_i; d_valid = dv; d_addr = a_d; d_wdata = w_d; d_wstrb = s_d;
        mem_ready = mr; mem_rdata = md;
        tmo = 0;
`ifdef MEM_ARBITER_TIMEOUT_EN
        tmo = act && !mr && (e - g == TO);
`endif
        e_ir = 0; e_dr = 0;
        if (act) begin
            if (mr || tmo) begin
                act = 0; nfree = e + 2; e_mv = 0; e_mi = 0;
                if (own_d) begin e_dr = 1; e_dd = mr ? md : 32'h0; end
                else begin e_ir = 1; e_id = mr ? md : 32'h0; end
                if (!mr) berr = 1;
            end
        end else if (e >= nfree && (iv || dv)) begin
            own_d = (iv && dv) ? !last_d : dv;
            last_d = own_d; act = 1; g = e;
            e_mv = 1; e_mi = !own_d;
            e_ma = own_d ? a_d : a_i;
            e_mw = own_d ? w_d : 32'h0;
            e_ms = own_d ? s_d : 4'h0;
        end
        @(posedge clk);
        #1;
        e++;
        chk("mem_valid", mem_valid, e_mv);
        chk("mem_instr", mem_instr, e_mi);
        if (e_mv) begin
            chk("mem_addr", mem_addr, e_ma);
            chk("mem_wdata", mem_wdata, e_mw);
            chk("mem_wstrb", mem_wstrb, e_ms);
        end
        chk("i_ready", i_ready, e_ir);
        chk("d_ready", d_ready, e_dr);
        chk("i_rdata", i_rdata, e_id);
        chk("d_rdata", d_rdata, e_dd);
        chk("bus_error", bus_error, berr);
    endtask

    task automatic idle(input logic mr);
        step(0, 0, 0, 0, 0, 0, mr, 32'h0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        idle(1); idle(0);
        reset = 1'b1;
        i_pend = 0; d_pend = 0; i_cool = 0; d_cool = 0; prev_mv = 0;
    endtask

    // Masters hold valid until their ready pulse and keep it low on the edge ending RESP.
    task automatic rand_run(input int n, input int pi, input int pd, input int pm);
        for (int k = 0; k < n; k++) begin
            if (!i_pend && !i_cool && $urandom_range(99) < pi) begin i_pend = 1; ia = $urandom; end
            if (!d_pend && !d_cool && $urandom_range(99) < pd) begin
                d_pend = 1; da = $urandom; dw = $urandom; ds = 4'($urandom);
            end
            i_cool = 0; d_cool = 0;
            step(i_pend, ia, d_pend, da, dw, ds, $urandom_range(99) < pm, $urandom);
            if (mem_valid && !prev_mv) order.push_back(!mem_instr);
            prev_mv = mem_valid;
            if (e_ir) begin i_pend = 0; i_cool = 1; end
            if (e_dr) begin d_pend = 0; d_cool = 1; end
        end
    endtask

    initial begin
        model_reset();
        idle(0); idle(0); idle(0);
        reset = 1'b1;
        for (int k = 0; k < 10; k++) begin
            idle(0);
            chk("reset_outputs_zero", {mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
                i_ready, i_rdata, d_ready, d_rdata, bus_error}, 160'h0);
        end

        // Instruction fetch, zero wait states
        step(1, 32'h100, 0, 0, 0, 0, 0, 0);
        chk("fetch_mem_valid", mem_valid, 1);
        chk("fetch_mem_instr", mem_instr, 1);
        chk("fetch_mem_wstrb", mem_wstrb, 0);
        chk("fetch_mem_addr", mem_addr, 32'h100);
        step(1, 32'h100, 0, 0, 0, 0, 1, 32'h13);
        chk("fetch_i_ready", i_ready, 1);
        chk("fetch_i_rdata", i_rdata, 32'h13);
        chk("fetch_d_ready", d_ready, 0);
        idle(0);
        chk("fetch_i_ready_drop", i_ready, 0);

        // Store with three wait states
        step(0, 0, 1, 32'h2000, 32'hDEADBEEF, 4'hF, 0, 0);
        chk("store_wstrb", mem_wstrb, 4'hF);
        chk("store_wdata", mem_wdata, 32'hDEADBEEF);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 1, 32'h2000, 32'hDEADBEEF, 4'hF, 0, 0);
            chk("store_wstrb_held", mem_wstrb, 4'hF);
            chk("store_wdata_held", mem_wdata, 32'hDEADBEEF);
            chk("store_mem_valid_held", mem_valid, 1);
        end
        step(0, 0, 1, 32'h2000, 32'hDEADBEEF, 4'hF, 1, 32'h12345678);
        chk("store_d_ready", d_ready, 1);
        idle(1);
        chk("store_single_pulse", d_ready, 0);

        // Simultaneous requests from reset alternate DATA, INSTR, DATA, INSTR
        do_reset();
        order.delete();
        rand_run(16, 100, 100, 100);
        chk("tie_grant_count", order.size() >= 4, 1);
        for (int k = 0; k < 4 && k < order.size(); k++) chk("tie_grant_order", order[k], (k % 2) == 0);

        // Asynchronous reset in the middle of REQ
        idle(0); idle(0); idle(0);
        step(0, 0, 1, 32'h3000, 32'h55, 4'h3, 0, 0);
        chk("pre_reset_mem_valid", mem_valid, 1);
        #3 reset = 1'b0;
        #1;
        chk("async_reset_mem_valid", mem_valid, 0);
        chk("async_reset_mem_addr", mem_addr, 0);
        model_reset();
        idle(1); idle(1);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            idle(1);
            chk("no_ready_after_reset", {i_ready, d_ready}, 0);
        end
        step(1, 32'h400, 0, 0, 0, 0, 0, 0);
        step(1, 32'h400, 0, 0, 0, 0, 1, 32'hABCD);
        chk("post_reset_i_ready", i_ready, 1);
        chk("post_reset_i_rdata", i_rdata, 32'hABCD);
        idle(0);

`ifdef MEM_ARBITER_TIMEOUT_EN
        step(0, 0, 1, 32'h5000, 0, 4'h0, 0, 0);
        step(0, 0, 1, 32'h5000, 0, 4'h0, 1, 32'hFFFFFFFF);
        idle(0);
        step(0, 0, 1, 32'h5004, 32'h77, 4'h1, 0, 0);
        for (int k = 0; k < TO - 1; k++) step(0, 0, 1, 32'h5004, 32'h77, 4'h1, 0, 0);
        chk("timeout_valid_before_expiry", mem_valid, 1);
        step(0, 0, 1, 32'h5004, 32'h77, 4'h1, 0, 0);
        chk("timeout_mem_valid", mem_valid, 0);
        chk("timeout_d_ready", d_ready, 1);
        chk("timeout_d_rdata", d_rdata, 0);
        chk("timeout_bus_error", bus_error, 1);
        idle(0);
        step(1, 32'h600, 0, 0, 0, 0, 0, 0);
        step(1, 32'h600, 0, 0, 0, 0, 1, 32'h99);
        idle(0);
        chk("bus_error_sticky", bus_error, 1);
`else
        step(0, 0, 1, 32'h5000, 32'h77, 4'h1, 0, 0);
        for (int k = 0; k < 300; k++) step(0, 0, 1, 32'h5000, 32'h77, 4'h1, 0, 0);
        chk("long_stall_mem_valid", mem_valid, 1);
        chk("long_stall_bus_error", bus_error, 0);
        step(0, 0, 1, 32'h5000, 32'h77, 4'h1, 1, 32'h5A5A5A5A);
        chk("long_stall_d_rdata", d_rdata, 32'h5A5A5A5A);
        idle(0);
`endif

        // Random traffic with variable wait states and stray mem_ready
        do_reset();
        rand_run(3000, 50, 50, 40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
